// File: rtl/display_scan_ctrl.sv
// Binary-to-BCD conversion FSM with atomic display-buffer commit and a multiplexed 4-digit tube scan.
// Optional leading-zero blanking is compiled in when DISPLAY_BLANK_ZERO_EN is defined.
module display_scan_ctrl #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic        clock_50H,
   input  logic        reset,
   input  logic [13:0] value,
   input  logic        load,
   output logic        busy,
   output logic        overflow,
   output logic [3:0]  new_num,
   output logic [3:0]  tube
);

   typedef enum logic [2:0] {S_IDLE, S_THOU, S_HUND, S_TENS, S_DONE} state_t;

   localparam logic [15:0] SCAN_TC = 16'(SCAN_DIV - 1);

   state_t            state_q, state_d;
   logic [13:0]       rem_q, rem_d;
   logic              ovf_tmp_q, ovf_tmp_d;
   logic [3:0][3:0]   dig_q, dig_d;
   logic [3:0][3:0]   disp_q, disp_d;
   logic              busy_q, busy_d;
   logic              overflow_q, overflow_d;
   logic [15:0]       presc_q, presc_d;
   logic [1:0]        idx_q, idx_d;
   logic [3:0]        tube_q, tube_d;
   logic [3:0]        num_q, num_d;
   logic              blank;

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      ovf_tmp_d  = ovf_tmp_q;
      dig_d      = dig_q;
      disp_d     = disp_q;
      busy_d     = busy_q;
      overflow_d = overflow_q;
      unique case (state_q)
         S_IDLE: if (load) begin
            rem_d     = (value > 14'd9999) ? 14'd9999 : value;
            ovf_tmp_d = (value > 14'd9999);
            dig_d     = '0;
            busy_d    = 1'b1;
            state_d   = S_THOU;
         end
         S_THOU: if (rem_q >= 14'd1000) begin
            rem_d    = rem_q - 14'd1000;
            dig_d[3] = dig_q[3] + 4'd1;
         end else begin
            state_d = S_HUND;
         end
         S_HUND: if (rem_q >= 14'd100) begin
            rem_d    = rem_q - 14'd100;
            dig_d[2] = dig_q[2] + 4'd1;
         end else begin
            state_d = S_TENS;
         end
         S_TENS: if (rem_q >= 14'd10) begin
            rem_d    = rem_q - 14'd10;
            dig_d[1] = dig_q[1] + 4'd1;
         end else begin
            dig_d[0] = rem_q[3:0];
            state_d  = S_DONE;
         end
         S_DONE: begin
            disp_d     = dig_q;
            overflow_d = ovf_tmp_q;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef DISPLAY_BLANK_ZERO_EN
   logic [1:0] msd;
   always_comb begin
      msd = 2'd0;
      for (int unsigned i = 1; i < 4; i++)
         if (disp_d[i] != 4'd0) msd = 2'(i);
      blank = (idx_d > msd);
   end
`else
   assign blank = 1'b0;
`endif

   // Outputs are computed from next-state index and buffer so tube, digit and commit land on one edge.
   always_comb begin
      presc_d = (presc_q == SCAN_TC) ? '0 : presc_q + 16'd1;
      idx_d   = (presc_q == SCAN_TC) ? idx_q + 2'd1 : idx_q;
      num_d   = disp_d[idx_d];
      tube_d  = blank ? 4'b1111 : ~(4'b0001 << idx_d);
   end

   always_ff @(posedge clock_50H) begin
      if (reset) begin
         state_q    <= S_IDLE;
         rem_q      <= '0;
         ovf_tmp_q  <= 1'b0;
         dig_q      <= '0;
         disp_q     <= '0;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
         presc_q    <= '0;
         idx_q      <= '0;
         tube_q     <= 4'b1110;
         num_q      <= '0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         ovf_tmp_q  <= ovf_tmp_d;
         dig_q      <= dig_d;
         disp_q     <= disp_d;
         busy_q     <= busy_d;
         overflow_q <= overflow_d;
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         tube_q     <= tube_d;
         num_q      <= num_d;
      end
   end

   assign busy     = busy_q;
   assign overflow = overflow_q;
   assign new_num  = num_q;
   assign tube     = tube_q;

endmodule
